// File: rtl/calc_pkg.sv
// -----------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the round-robin calculator scheduler:
//   - calculator op codes
//   - scheduler FSM state encoding
//   - result value reported for a divide by zero
// -----------------------------------------------------------------------------
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [7:0] DIV0_RESULT = 8'hFF;

endpackage

// File: rtl/calc_core.sv
// -----------------------------------------------------------------------------
// calc_core
// Combinational 4-bit calculator with an 8-bit unsigned result.
// Ports:
//   a_i, b_i [3:0]  operands
//   op_i     [1:0]  00 add, 01 sub (wraps mod 256), 10 mul, 11 div (truncating)
//   result_o [7:0]  result; a zero divisor yields 0 here and is handled by
//                   the caller
// -----------------------------------------------------------------------------
module calc_core
    import calc_pkg::*;
(
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic [1:0] op_i,
    output logic [7:0] result_o
);

    always_comb begin
        result_o = '0;
        case (op_i)
            OP_ADD:  result_o = {4'd0, a_i} + {4'd0, b_i};
            OP_SUB:  result_o = {4'd0, a_i} - {4'd0, b_i};
            OP_MUL:  result_o = {4'd0, a_i} * {4'd0, b_i};
            OP_DIV:  result_o = (b_i == 4'd0) ? 8'd0 : {4'd0, a_i / b_i};
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. Grants the first asserted request
// at or after the pointer, wrapping modulo N_REQ.
// Ports:
//   req_i   [N_REQ-1:0]  request vector
//   ptr_i   [PW-1:0]     highest-priority index
//   grant_o [N_REQ-1:0]  one-hot grant, zero when no request is set
// -----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_REQ = 4,
    localparam int PW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    output logic [N_REQ-1:0] grant_o
);

    logic found;
    int   idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/calc_rr_scheduler.sv
// -----------------------------------------------------------------------------
// calc_rr_scheduler
// Shares one calculator between N_REQ requesters. A round-robin arbiter picks
// a requester in IDLE; its operands are registered, evaluated in EXEC, and
// the tagged result is presented in RESP until the consumer accepts it.
// Optional build macro CALC_SCHED_STATS_EN adds saturating op/err counters.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/req_ready      per-requester handshake (ready one-hot or zero)
//   req_a/req_b [4*N_REQ]    operands, requester i at [4i+3:4i]
//   req_op      [2*N_REQ]    op code, requester i at [2i+1:2i]
//   resp_valid/resp_ready    response handshake
//   resp_id, resp_result, resp_err   tagged response
//   op_count, err_count      (CALC_SCHED_STATS_EN only) response statistics
// -----------------------------------------------------------------------------
module calc_rr_scheduler
    import calc_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [4*N_REQ-1:0] req_a,
    input  logic [4*N_REQ-1:0] req_b,
    input  logic [2*N_REQ-1:0] req_op,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [ID_W-1:0]    resp_id,
    output logic [7:0]         resp_result,
    output logic               resp_err
`ifdef CALC_SCHED_STATS_EN
    ,
    output logic [15:0]        op_count,
    output logic [7:0]         err_count
`endif
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   gnt_id;
    logic [3:0]        a_q, b_q;
    logic [1:0]        op_q;
    logic [ID_W-1:0]   id_q;
    logic [7:0]        res_q;
    logic [ID_W-1:0]   rid_q;
    logic              err_q;
    logic [7:0]        calc_res;
    logic              req_hs;
    logic              resp_hs;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant)
    );

    calc_core u_calc (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (op_q),
        .result_o (calc_res)
    );

    always_comb begin
        gnt_id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) gnt_id = ID_W'(i);
        end
    end

    always_comb begin
        ptr_d = (int'(gnt_id) == N_REQ - 1) ? '0 : gnt_id + 1'b1;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs)  state_d = EXEC;
            EXEC:                 state_d = RESP;
            RESP:    if (resp_hs) state_d = IDLE;
            default:              state_d = IDLE;
        endcase
    end

    // Outputs; the grant is masked while rst is high so req_ready reads zero
    // during reset even though the state register already shows IDLE.
    always_comb begin
        req_ready  = (state_q == IDLE && !rst) ? grant : '0;
        resp_valid = (state_q == RESP);
    end

    assign req_hs  = |req_ready;
    assign resp_hs = resp_valid & resp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            id_q  <= '0;
            res_q <= '0;
            rid_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (req_hs) begin
                a_q   <= req_a[4*int'(gnt_id) +: 4];
                b_q   <= req_b[4*int'(gnt_id) +: 4];
                op_q  <= req_op[2*int'(gnt_id) +: 2];
                id_q  <= gnt_id;
                ptr_q <= ptr_d;
            end
            if (state_q == EXEC) begin
                rid_q <= id_q;
                // Divide by zero overrides whatever the calculator produced.
                if (op_q == OP_DIV && b_q == 4'd0) begin
                    res_q <= DIV0_RESULT;
                    err_q <= 1'b1;
                end else begin
                    res_q <= calc_res;
                    err_q <= 1'b0;
                end
            end
        end
    end

    assign resp_id     = rid_q;
    assign resp_result = res_q;
    assign resp_err    = err_q;

`ifdef CALC_SCHED_STATS_EN
    logic [15:0] op_cnt_q;
    logic [7:0]  err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else if (resp_hs) begin
            if (op_cnt_q != 16'hFFFF)       op_cnt_q  <= op_cnt_q + 16'd1;
            if (err_q && err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign op_count  = op_cnt_q;
    assign err_count = err_cnt_q;
`endif

endmodule
